seq_det_ctrl: RTL and testbench
===============================

// Module: seq_det_ctrl
// PURPOSE
//  Sequencer for the serial 11011 detector (seq_det: in, clk, rst, out; Moore, overlapping).
//  Accepts parallel words over valid/ready and drives them MSB-first into the detector, one bit per clock.
//  Counts detector hits, then flushes the detector back to s0 so words are scored independently.
//  Returns a per-word result over valid/ready. The detector sits beside this block, on the same clk/rst.
// PARAMETERS
//  WORD_W  16  bits per input word (>=2)
//  CNT_W   5   width of the match counter; the count saturates
// PORTS
//  clk            in   1          single clock, rising edge
//  rst            in   1          asynchronous, active-high reset; also resets the detector
//  word_in        in   WORD_W     word to scan; bit WORD_W-1 is sent first
//  word_valid     in   1          word_in is valid
//  word_ready     out  1          high only in IDLE
//  det_in         out  1          serial bit to detector 'in'
//  det_out        in   1          detector 'out'
//  res_valid      out  1          result valid; held until res_ready
//  res_ready      in   1          consumer accepts the result
//  res_count      out  CNT_W      number of matches in the word (saturating)
//  res_hit        out  1          res_count != 0
//  busy           out  1          state != IDLE
// BEHAVIOUR
//  - Reset (async): state=IDLE. det_in, res_valid, res_count, res_hit, busy and all internal registers = 0.
//    word_ready=1 once rst is released. The shared rst puts the detector in s0.
//  - FSM: IDLE -> SHIFT -> FLUSH0 -> FLUSH1 -> RESULT -> IDLE.
//  - IDLE: det_in=0. On word_valid&&word_ready: load shift reg, idx=0, count=0, go to SHIFT.
//  - SHIFT: det_in = shreg[WORD_W-1]. Each cycle: shift left, idx++. Leave for FLUSH0 after idx==WORD_W-1.
//  - Detector out lags its input by one cycle. A match ending at bit p is seen on det_out in the cycle after bit p is driven.
//    det_out is sampled in SHIFT when idx>=1 and in FLUSH0. It is ignored in every other state.
//  - FLUSH0 and FLUSH1: det_in=0. Two zeros take the detector from any state back to s0.
//    On entry to RESULT the detector is in s0. No match can span two words.
//  - RESULT: res_valid=1. res_count, res_hit and the optional fields hold stable until res_ready.
//    On res_valid&&res_ready go to IDLE.
//  - Counter: +1 per sampled det_out=1. It saturates at 2^CNT_W-1 and never wraps.
//  - Latency: word accepted in cycle 0 -> SHIFT in cycles 1..W -> FLUSH in cycles W+1..W+2 -> res_valid from cycle W+3.
//    For W=16, res_valid rises in cycle 19. Peak rate is one word per W+4 cycles.
//  - Backpressure: while res_ready=0, RESULT is held, word_ready=0 and det_in=0.
//  - word_valid outside IDLE is ignored. word_in is only sampled at acceptance.
//  - rst asserted mid-word: the word and its partial count are discarded.
//    No res_valid is produced for it. The block restarts in IDLE.
// CONFIGURATION
//  SEQDET_FIRSTPOS_EN defined:
//    Adds output res_first_pos [$clog2(WORD_W)-1:0].
//    It holds the bit index p (0 = first bit sent) of the last bit of the first match.
//    It is 0 when res_hit=0, resets to 0, and is held with the other result fields.
//  SEQDET_FIRSTPOS_EN undefined: the port and its logic are absent. All other behaviour is identical.
// TESTING (WORD_W=16, CNT_W=5)
//  1. 0xD800 -> res_count=1, res_hit=1, first_pos=4. res_valid rises 19 cycles after acceptance.
//  2. 0xDB60 (overlapping matches) -> res_count=3, first_pos=4 (matches end at p=4, 7 and 10).
//  3. 0x001B (match ends on the last bit, sampled in FLUSH0) -> res_count=1, first_pos=15.
//  4. 0x0003 then 0x6000 back-to-back (11|011 across the boundary) -> both results count=0, hit=0.
//     0xFFFF -> count=0.
//  5. res_ready held low 5 cycles in RESULT -> res_valid and fields stable, word_ready=0, det_in=0.
//     Then one handshake -> IDLE.
//  6. rst pulse at SHIFT idx=7 -> all outputs 0 immediately, no result emitted.
//     The next word 0xD800 gives count=1.

Source files
------------

// File: rtl/seq_det_ctrl.sv
// seq_det_ctrl: sequencer for a serial 11011 detector (Moore, overlapping).
// Takes parallel words over valid/ready and shifts them MSB-first into the
// detector. It counts the detector hits, then drives two zeros to flush the
// detector back to s0. It returns one result per word over valid/ready.
// Optional feature macro: SEQDET_FIRSTPOS_EN adds res_first_pos, the bit
// index of the last bit of the first match.
module seq_det_ctrl #(
  parameter int WORD_W = 16,
  parameter int CNT_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] word_in,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              det_in,
  input  logic              det_out,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [CNT_W-1:0]  res_count,
  output logic              res_hit,
`ifdef SEQDET_FIRSTPOS_EN
  output logic [$clog2(WORD_W)-1:0] res_first_pos,
`endif
  output logic              busy
);

  localparam int                IDX_W    = $clog2(WORD_W);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(WORD_W - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SHIFT  = 3'd1,
    FLUSH0 = 3'd2,
    FLUSH1 = 3'd3,
    RESULT = 3'd4
  } state_t;

  state_t             state, state_nxt;
  logic [WORD_W-1:0]  shreg;
  logic [IDX_W-1:0]   idx;
  logic [CNT_W-1:0]   count;
  logic               sample;
  logic               accept;

`ifdef SEQDET_FIRSTPOS_EN
  logic               found;
  logic [IDX_W-1:0]   first_pos;
`endif

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking (=) here would create order-dependent races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and handshake/serial outputs.
  // NOTE: every output gets a default first, so no path through the case
  // leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_nxt  = state;
    word_ready = 1'b0;
    det_in     = 1'b0;
    res_valid  = 1'b0;
    busy       = 1'b1;
    sample     = 1'b0;
    case (state)
      IDLE: begin
        word_ready = 1'b1;
        busy       = 1'b0;
        if (word_valid) state_nxt = SHIFT;
      end
      SHIFT: begin
        det_in = shreg[WORD_W-1];
        // det_out lags by one cycle; at idx 0 it still reflects the flush.
        sample = (idx != '0);
        if (idx == IDX_LAST) state_nxt = FLUSH0;
      end
      FLUSH0: begin
        // Carries the detector's verdict on the word's last bit.
        sample    = 1'b1;
        state_nxt = FLUSH1;
      end
      FLUSH1: state_nxt = RESULT;
      RESULT: begin
        res_valid = 1'b1;
        if (res_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign accept = (state == IDLE) && word_valid;

  // Datapath: shift register, bit index, saturating match count, first match.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg     <= '0;
      idx       <= '0;
      count     <= '0;
`ifdef SEQDET_FIRSTPOS_EN
      found     <= 1'b0;
      first_pos <= '0;
`endif
    end else begin
      if (accept) begin
        shreg     <= word_in;
        idx       <= '0;
        count     <= '0;
`ifdef SEQDET_FIRSTPOS_EN
        found     <= 1'b0;
        first_pos <= '0;
`endif
      end else if (state == SHIFT) begin
        shreg <= {shreg[WORD_W-2:0], 1'b0};
        idx   <= idx + IDX_W'(1);
      end
      if (sample && det_out) begin
        if (count != CNT_MAX) count <= count + CNT_W'(1);
`ifdef SEQDET_FIRSTPOS_EN
        // The hit seen now belongs to the bit driven one cycle earlier.
        if (!found) begin
          found     <= 1'b1;
          first_pos <= (state == FLUSH0) ? IDX_LAST : idx - IDX_W'(1);
        end
`endif
      end
    end
  end

  assign res_count = count;
  assign res_hit   = (count != '0);
`ifdef SEQDET_FIRSTPOS_EN
  assign res_first_pos = first_pos;
`endif

endmodule

// File: tb/tb_seq_det_ctrl.sv
// tb_seq_det_ctrl: self-checking bench for seq_det_ctrl (WORD_W=16, CNT_W=5).
// A behavioural 11011 detector sits beside the DUT. Expected results come
// from counting 11011 windows directly in each word's transmitted bits.
// The optional SEQDET_FIRSTPOS_EN macro is honoured.
module tb_seq_det_ctrl;

  localparam int W  = 16;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  word_in;
  logic          word_valid;
  logic          word_ready;
  logic          det_in;
  logic          det_out;
  logic          res_valid;
  logic          res_ready;
  logic [CW-1:0] res_count;
  logic          res_hit;
  logic          busy;
`ifdef SEQDET_FIRSTPOS_EN
  logic [$clog2(W)-1:0] res_first_pos;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  seq_det_ctrl #(.WORD_W(W), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .word_in    (word_in),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .det_in     (det_in),
    .det_out    (det_out),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_count  (res_count),
    .res_hit    (res_hit),
`ifdef SEQDET_FIRSTPOS_EN
    .res_first_pos (res_first_pos),
`endif
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Detector: out is high the cycle after the last five input bits read 11011.
  logic [4:0] hist;
  always @(posedge clk or posedge rst) begin
    if (rst) hist <= '0;
    else     hist <= {hist[3:0], det_in};
  end
  assign det_out = (hist == 5'b11011);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: count 11011 windows in the bits sent (bit p is word[W-1-p]).
  function automatic void model(input logic [W-1:0] w, output int cnt, output int fp);
    logic [4:0] win;
    cnt = 0;
    fp  = 0;
    for (int p = 4; p < W; p++) begin
      for (int k = 0; k < 5; k++) win[4-k] = w[W-1-(p-4+k)];
      if (win == 5'b11011) begin
        if (cnt == 0) fp = p;
        cnt++;
      end
    end
    if (cnt > (1 << CW) - 1) cnt = (1 << CW) - 1;
  endfunction

  // Send one word, hold the result for 'hold' cycles, then take it.
  task automatic run_word(input logic [W-1:0] w, input int hold);
    int          exp_cnt, exp_fp, lat;
    logic [CW-1:0] snap;
    model(w, exp_cnt, exp_fp);
    check("ready_in_idle", word_ready, 1);
    word_in    = w;
    word_valid = 1'b1;
    @(posedge clk); #1;
    word_valid = 1'b0;
    word_in    = W'($urandom);
    check("busy_after_accept", busy, 1);
    check("not_ready_in_shift", word_ready, 0);
    lat = 1;
    while (!res_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, W + 3);
    check("count", res_count, exp_cnt);
    check("hit", res_hit, exp_cnt != 0);
`ifdef SEQDET_FIRSTPOS_EN
    check("first_pos", res_first_pos, exp_fp);
`endif
    snap = res_count;
    for (int i = 0; i < hold; i++) begin
      word_valid = 1'b1;
      word_in    = W'($urandom);
      @(posedge clk); #1;
      check("hold_valid", res_valid, 1);
      check("hold_count", res_count, snap);
      check("hold_word_ready", word_ready, 0);
      check("hold_det_in", det_in, 0);
    end
    word_valid = 1'b0;
    res_ready  = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    check("valid_after_handshake", res_valid, 0);
    check("idle_after_handshake", word_ready, 1);
    check("not_busy_after_handshake", busy, 0);
  endtask

  initial begin
    int seen;
    rst        = 1'b1;
    word_in    = '0;
    word_valid = 1'b0;
    res_ready  = 1'b0;
    #2;
    check("rst_res_valid", res_valid, 0);
    check("rst_res_count", res_count, 0);
    check("rst_res_hit", res_hit, 0);
    check("rst_busy", busy, 0);
    check("rst_det_in", det_in, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("ready_after_rst", word_ready, 1);

    // Directed cases.
    run_word(16'hD800, 0);
    run_word(16'hDB60, 0);
    run_word(16'h001B, 1);
    run_word(16'h0003, 0);
    run_word(16'h6000, 0);
    run_word(16'hFFFF, 0);
    run_word(16'hD800, 5);

    // Reset in the middle of a word: SHIFT with idx=7.
    word_in    = 16'hDB60;
    word_valid = 1'b1;
    @(posedge clk); #1;
    word_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check("pre_rst_busy", busy, 1);
    rst = 1'b1;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_det_in", det_in, 0);
    check("midrst_res_valid", res_valid, 0);
    check("midrst_count", res_count, 0);
    check("midrst_hit", res_hit, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("midrst_ready", word_ready, 1);
    seen = 0;
    res_ready = 1'b1;
    repeat (25) begin
      @(posedge clk); #1;
      if (res_valid) seen++;
    end
    res_ready = 1'b0;
    check("no_result_after_rst", seen, 0);
    run_word(16'hD800, 0);

    // Randomized words and backpressure.
    for (int i = 0; i < 30; i++) begin
      logic [W-1:0] w;
      w = W'($urandom);
      if ($urandom_range(0, 1) == 1) w[W-1-$urandom_range(0, W-5) -: 5] = 5'b11011;
      run_word(w, $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
